pc_ras: RTL

- Parametrised program-counter unit; next generation of the core's PC block.
- Generalised datapath and displacement widths, plus a hardware return-address stack (RAS) for call/return.
- Sits at the fetch stage: drives the instruction-memory address and takes branch/jump/call/ret decodes from the controller.
- A compile-time option adds an interrupt vector redirect.

---
 rtl/pc_ras.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pc_ras.sv
// pc_ras: parametrised fetch-stage program counter with a hardware
// return-address stack (RAS) for call/return.
//
// Optional feature: define PC_IRQ_EN to enable the interrupt vector redirect.
// Without it the irq port is present but has no effect.
//
// The RAS is a circular buffer addressed by a top pointer plus a saturating
// occupancy count. A push onto a full stack overwrites the oldest entry.
// ras_top, ras_empty and ras_full come from registered state only.
module pc_ras #(
  parameter int                   DATAWIDTH = 16,
  parameter int                   DISPWIDTH = 8,
  parameter int                   RAS_DEPTH = 4,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = DATAWIDTH'(16'h0000),
  parameter logic [DATAWIDTH-1:0] IRQ_VEC   = DATAWIDTH'(16'h0008)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pcEn,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 call,
  input  logic                 ret,
  input  logic                 irq,
  input  logic [DISPWIDTH-1:0] disp,
  input  logic [DATAWIDTH-1:0] dSrc,
  output logic [DATAWIDTH-1:0] pc,
  output logic [DATAWIDTH-1:0] pc_ra,
  output logic [DATAWIDTH-1:0] ras_top,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_err
);

  localparam int                   PTR_W    = $clog2(RAS_DEPTH);
  localparam int                   CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [DATAWIDTH-1:0] PC_ONE   = DATAWIDTH'(1);

  // Architectural state
  logic [DATAWIDTH-1:0] pc_r;
  logic [DATAWIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]     top_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 err_r;

  // Next-state controls
  logic [DATAWIDTH-1:0] disp_ext_s;
  logic [DATAWIDTH-1:0] seq_pc_s;
  logic [DATAWIDTH-1:0] pc_ra_s;
  logic [DATAWIDTH-1:0] ras_top_s;
  logic [DATAWIDTH-1:0] pc_next_s;
  logic [DATAWIDTH-1:0] push_data_s;
  logic [PTR_W-1:0]     push_idx_s;
  logic                 ras_empty_s;
  logic                 ras_full_s;
  logic                 irq_take_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 err_set_s;

`ifdef PC_IRQ_EN
  assign irq_take_s = irq;
`else
  // irq is accepted on the port but never acted upon in this build.
  logic unused_irq_s;
  assign unused_irq_s = irq;
  assign irq_take_s   = 1'b0;
`endif

  assign disp_ext_s  = DATAWIDTH'($signed(disp));
  assign seq_pc_s    = pc_r + PC_ONE;
  assign pc_ra_s     = branch ? (pc_r + disp_ext_s) : seq_pc_s;
  assign ras_empty_s = (cnt_r == {CNT_W{1'b0}});
  assign ras_full_s  = (cnt_r == CNT_FULL);
  assign ras_top_s   = ras_empty_s ? {DATAWIDTH{1'b0}} : ras_mem_r[top_r];
  assign push_idx_s  = top_r + PTR_ONE;

  // Select the next PC and the RAS action by decode priority: irq, ret, call, jump, branch/sequential.
  always_comb begin
    pc_next_s   = pc_ra_s;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_data_s = seq_pc_s;
    err_set_s   = 1'b0;
    if (irq_take_s) begin
      // Return to the instruction that was pre-empted, not the one after it.
      pc_next_s   = IRQ_VEC;
      push_s      = 1'b1;
      push_data_s = pc_r;
    end else if (ret) begin
      // A simultaneous call is dropped and flagged; an empty pop is flagged.
      err_set_s = call | ras_empty_s;
      if (ras_empty_s) begin
        pc_next_s = seq_pc_s;
      end else begin
        pc_next_s = ras_top_s;
        pop_s     = 1'b1;
      end
    end else if (call) begin
      // Return address is always the sequential successor; branch is ignored.
      pc_next_s   = dSrc;
      push_s      = 1'b1;
      push_data_s = seq_pc_s;
    end else if (jump) begin
      pc_next_s = dSrc;
    end else begin
      pc_next_s = pc_ra_s;
    end
  end

  // PC, stack pointer, occupancy count and sticky error update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r  <= RESET_PC;
      top_r <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      err_r <= 1'b0;
    end else if (pcEn) begin
      pc_r <= pc_next_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end
      if (push_s) begin
        top_r <= push_idx_s;
        if (!ras_full_s) begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else if (pop_s) begin
        top_r <= top_r - PTR_ONE;
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Stack storage; stale entries are masked by the occupancy count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst && pcEn && push_s) begin
      ras_mem_r[push_idx_s] <= push_data_s;
    end
  end

  assign pc        = pc_r;
  assign pc_ra     = pc_ra_s;
  assign ras_top   = ras_top_s;
  assign ras_empty = ras_empty_s;
  assign ras_full  = ras_full_s;
  assign ras_err   = err_r;

endmodule
